// File: rtl/mem_stream_reader_if.sv
// Command, RAM read and FIFO write bundle for the memory stream reader.
// master = the reader engine, slave = the surrounding system (RAM, FIFO, controller).
interface mem_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
);
  logic                  cmdValidIn;
  logic                  cmdReadyOut;
  logic [ADDR_WIDTH-1:0] cmdAddrIn;
  logic [LEN_WIDTH-1:0]  cmdLenIn;
  logic                  memRdEnOut;
  logic [ADDR_WIDTH-1:0] memRdAddrOut;
  logic [DATA_WIDTH-1:0] memRdDataIn;
  logic [DATA_WIDTH-1:0] wrDataOut;
  logic                  wrValidOut;
  logic                  wrReadyIn;
  logic                  busyOut;
  logic                  doneOut;

  modport master (
    input  cmdValidIn, cmdAddrIn, cmdLenIn, memRdDataIn, wrReadyIn,
    output cmdReadyOut, memRdEnOut, memRdAddrOut, wrDataOut, wrValidOut,
           busyOut, doneOut
  );

  modport slave (
    output cmdValidIn, cmdAddrIn, cmdLenIn, memRdDataIn, wrReadyIn,
    input  cmdReadyOut, memRdEnOut, memRdAddrOut, wrDataOut, wrValidOut,
           busyOut, doneOut
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Block-read engine: issues one RAM read per cycle over a word range and
// forwards returned words as posted writes into the stream FIFO.
module mem_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic clkIn,
  input  logic rstNIn,
  mem_stream_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  // All in-flight stages except the oldest, which leaves the pipe this cycle.
  localparam logic [MEM_LATENCY-1:0] INNER_MASK = {MEM_LATENCY{1'b1}} >> 1;

  state_t                 state;
  state_t                 stateNext;
  logic [ADDR_WIDTH-1:0]  addrR;
  logic [LEN_WIDTH-1:0]   remR;
  logic [MEM_LATENCY-1:0] vldP;
  logic                   doneR;
  logic                   accept;
  logic                   issue;
  logic                   drained;

  assign accept  = (state == IDLE) && bus.cmdValidIn;
  assign issue   = (state == ISSUE) && bus.wrReadyIn;
  assign drained = (vldP & INNER_MASK) == '0;

  always_ff @(posedge clkIn) begin
    if (!rstNIn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && (bus.cmdLenIn != '0)) stateNext = ISSUE;
      ISSUE:   if (issue && (remR == LEN_WIDTH'(1))) stateNext = DRAIN;
      DRAIN:   if (drained) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.cmdReadyOut  = (state == IDLE);
    bus.busyOut      = (state != IDLE);
    bus.memRdEnOut   = issue;
    bus.memRdAddrOut = addrR;
    bus.wrValidOut   = vldP[MEM_LATENCY-1];
    bus.wrDataOut    = bus.memRdDataIn;
    bus.doneOut      = doneR;
  end

  // Issue stage -> in-flight valid pipe (stage 0 newest), plus range counters.
  // doneR is registered on the cycle the pipe empties so that done coincides
  // with the return to IDLE.
  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      vldP  <= '0;
      doneR <= 1'b0;
      addrR <= '0;
      remR  <= '0;
    end else begin
      vldP  <= MEM_LATENCY'({vldP, issue});
      doneR <= (accept && (bus.cmdLenIn == '0)) || ((state == DRAIN) && drained);
      if (accept) begin
        addrR <= bus.cmdAddrIn;
        remR  <= bus.cmdLenIn;
      end else if (issue) begin
        addrR <= addrR + ADDR_WIDTH'(1);
        remR  <= remR - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a two-cycle-latency RAM model.
module tb_mem_stream_reader;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int L  = 2;

  logic clkIn  = 1'b0;
  logic rstNIn = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc <= cyc + 1;

  mem_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus();

  mem_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MEM_LATENCY(L)
  ) dut (
    .clkIn (clkIn),
    .rstNIn(rstNIn),
    .bus   (bus)
  );

  function automatic logic [31:0] ramWord(input logic [15:0] a);
    return 32'h0000_A000 + {16'h0000, a};
  endfunction

  // RAM model: data for the address presented at edge t appears two cycles later.
  logic [31:0] rdP1, rdP2;
  always @(posedge clkIn) begin
    rdP1 <= ramWord(bus.memRdAddrOut);
    rdP2 <= rdP1;
  end
  assign bus.memRdDataIn = rdP2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [15:0] addrQ[$];
  logic [31:0] dataQ[$];
  int doneCycQ[$];
  int strCycQ[$];
  int wrCycQ[$];
  int busyCnt = 0;

  always @(negedge clkIn) begin
    if (bus.memRdEnOut === 1'b1) begin
      strCycQ.push_back(cyc);
      chk("strobe_gated", {31'b0, bus.wrReadyIn}, 32'd1);
      if (addrQ.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
      else chk("rd_addr", {16'b0, bus.memRdAddrOut}, {16'b0, addrQ.pop_front()});
    end
    if (bus.wrValidOut === 1'b1) begin
      wrCycQ.push_back(cyc);
      if (dataQ.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else chk("wr_data", bus.wrDataOut, dataQ.pop_front());
    end
    if (bus.doneOut === 1'b1) doneCycQ.push_back(cyc);
    if (bus.busyOut === 1'b1) busyCnt++;
  end

  task automatic clearStats();
    doneCycQ.delete();
    strCycQ.delete();
    wrCycQ.delete();
    busyCnt = 0;
  endtask

  task automatic chkIdle();
    chk("idle_cmdReady", {31'b0, bus.cmdReadyOut}, 32'd1);
    chk("idle_rdEn",     {31'b0, bus.memRdEnOut},  32'd0);
    chk("idle_rdAddr",   {16'b0, bus.memRdAddrOut}, 32'd0);
    chk("idle_wrValid",  {31'b0, bus.wrValidOut},  32'd0);
    chk("idle_busy",     {31'b0, bus.busyOut},     32'd0);
    chk("idle_done",     {31'b0, bus.doneOut},     32'd0);
  endtask

  // Pushes expectations, presents the command and returns the handshake cycle.
  task automatic doCmd(input logic [15:0] a, input logic [15:0] n, output int acc);
    logic [15:0] ad;
    ad = a;
    for (int i = 0; i < int'(n); i++) begin
      addrQ.push_back(ad);
      dataQ.push_back(ramWord(ad));
      ad = ad + 16'd1;
    end
    bus.cmdAddrIn  = a;
    bus.cmdLenIn   = n;
    bus.cmdValidIn = 1'b1;
    acc = -1;
    for (int k = 0; k < 200 && acc < 0; k++) begin
      if (bus.cmdReadyOut === 1'b1) acc = cyc;
      @(posedge clkIn); #1;
    end
    bus.cmdValidIn = 1'b0;
    if (acc < 0) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDones(input int n);
    for (int k = 0; k < 300 && doneCycQ.size() < n; k++) begin
      @(posedge clkIn); #1;
    end
    if (doneCycQ.size() < n) chk("done_timeout", doneCycQ.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, gap;
    bus.cmdValidIn = 1'b0;
    bus.cmdAddrIn  = '0;
    bus.cmdLenIn   = '0;
    bus.wrReadyIn  = 1'b1;
    rstNIn = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
    rstNIn = 1'b1;
    chkIdle();

    // Basic: addr 0x10, len 4
    clearStats();
    doCmd(16'h0010, 16'd4, t);
    waitDones(1);
    chk("basic_done_cyc", doneCycQ[0], t + 7);
    chk("basic_strobes", strCycQ.size(), 4);
    chk("basic_first_strobe", strCycQ[0], t + 1);
    chk("basic_writes", wrCycQ.size(), 4);
    chk("basic_first_wr", wrCycQ[0], t + 3);
    chk("basic_last_wr", wrCycQ[wrCycQ.size() - 1], t + 6);
    chk("basic_busy_cycles", busyCnt, 6);

    // Throttle: ready low for T+3..T+5
    clearStats();
    doCmd(16'h0100, 16'd8, t);
    @(posedge clkIn); #1;
    @(posedge clkIn); #1;
    bus.wrReadyIn = 1'b0;
    repeat (3) begin @(posedge clkIn); #1; end
    bus.wrReadyIn = 1'b1;
    waitDones(1);
    gap = 0;
    foreach (strCycQ[i]) if (strCycQ[i] >= t + 3 && strCycQ[i] <= t + 5) gap++;
    chk("throttle_gap", gap, 0);
    chk("throttle_done_cyc", doneCycQ[0], t + 14);
    chk("throttle_strobes", strCycQ.size(), 8);
    chk("throttle_writes", wrCycQ.size(), 8);

    // Address wrap
    clearStats();
    doCmd(16'hFFFE, 16'd4, t);
    waitDones(1);
    chk("wrap_done_cyc", doneCycQ[0], t + 7);
    chk("wrap_writes", wrCycQ.size(), 4);

    // Zero length
    clearStats();
    doCmd(16'h0200, 16'd0, t);
    waitDones(1);
    repeat (3) begin @(posedge clkIn); #1; end
    chk("zero_done_cyc", doneCycQ[0], t + 1);
    chk("zero_dones", doneCycQ.size(), 1);
    chk("zero_strobes", strCycQ.size(), 0);
    chk("zero_writes", wrCycQ.size(), 0);
    chk("zero_busy", busyCnt, 0);

    // Back-to-back: second command held while the first is busy
    clearStats();
    doCmd(16'h0020, 16'd3, t);
    doCmd(16'h0030, 16'd2, t2);
    waitDones(2);
    chk("b2b_done1_cyc", doneCycQ[0], t + 6);
    chk("b2b_accept_cyc", t2, t + 6);
    chk("b2b_first_strobe2", strCycQ[3], t2 + 1);
    chk("b2b_done2_cyc", doneCycQ[1], t2 + 5);
    chk("b2b_writes", wrCycQ.size(), 5);

    // Reset with two reads in flight
    clearStats();
    doCmd(16'h0040, 16'd8, t);
    @(posedge clkIn); #1;
    rstNIn = 1'b0;
    @(posedge clkIn); #1;
    rstNIn = 1'b1;
    addrQ.delete();
    dataQ.delete();
    clearStats();
    chkIdle();
    repeat (10) begin @(posedge clkIn); #1; end
    chk("rst_no_writes", wrCycQ.size(), 0);
    chk("rst_no_done", doneCycQ.size(), 0);
    chk("rst_no_strobes", strCycQ.size(), 0);

    // Recovery with a single-word command
    clearStats();
    doCmd(16'h0050, 16'd1, t);
    waitDones(1);
    chk("one_done_cyc", doneCycQ[0], t + 4);
    chk("one_writes", wrCycQ.size(), 1);

    chk("sb_data_empty", dataQ.size(), 0);
    chk("sb_addr_empty", addrQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
